// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the RX and TX paths.
//   UART_OVERSAMPLE_DEFAULT : default ticks per bit period
//   UART_DIV_WIDTH_DEFAULT  : default width of the baud divisor
//   majority3()             : 2-of-3 vote used by the optional RX line filter
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;
  localparam int UART_DIV_WIDTH_DEFAULT  = 16;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Programmable tick generator, shared by the RX and TX paths. Emits one
// single-cycle clk_en pulse every baud_div+1 clk cycles while enabled.
//
// Ports
//   clk      in  : system clock
//   reset    in  : asynchronous, active-high reset
//   en       in  : enable; when low the counter is held at 0 and no ticks
//   baud_div in  : tick period minus one, in clk cycles
//   clk_en   out : oversampling tick, one clk cycle wide
// ---------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = UART_DIV_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 clk_en
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick_q;

  // The >= compare (rather than ==) makes a lowered divisor take effect at
  // once: a counter already past the new limit wraps on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (div_cnt >= baud_div) begin
      div_cnt <= '0;
      tick_q  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
      tick_q  <= 1'b0;
    end
  end

  // Gate with en so a tick registered just before disable never leaks out.
  assign clk_en = tick_q & en;

endmodule

// File: rtl/uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend
// Receive-side front end: synchronises the rx pin, filters it on baud ticks,
// detects start-bit falling edges and produces the mid-bit sample strobe.
//
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   defined   -> rx_sync is the 2-of-3 majority of the last three tick samples
//   undefined -> rx_sync takes the synchronised pin value on each tick
//
// Ports
//   clk                 in  : system clock
//   reset               in  : asynchronous, active-high reset
//   rx_en               in  : receiver enable
//   baud_div            in  : tick period is baud_div+1 clk cycles
//   rx                  in  : raw asynchronous serial input
//   rx_sample_cnt_reset in  : restart bit timing (honoured on ticks only)
//   rx_clk_en           out : oversampling tick
//   rx_sync             out : filtered, registered line level
//   rx_sync_fall        out : falling edge of rx_sync, tick-qualified
//   rx_get_sample       out : mid-bit sample strobe, tick-qualified
// ---------------------------------------------------------------------------
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
  parameter int DIV_WIDTH  = UART_DIV_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx,
  input  logic                 rx_sample_cnt_reset,
  output logic                 rx_clk_en,
  output logic                 rx_sync,
  output logic                 rx_sync_fall,
  output logic                 rx_get_sample
);

  localparam int                    SMP_WIDTH = $clog2(OVERSAMPLE);
  localparam logic [SMP_WIDTH-1:0]  SMP_MID   = SMP_WIDTH'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_WIDTH-1:0]  SMP_ONE   = SMP_WIDTH'(1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_filt;
  logic                 rx_sync_prev;
  logic [SMP_WIDTH-1:0] smp_cnt;

  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (rx_en),
    .baud_div (baud_div),
    .clk_en   (rx_clk_en)
  );

  // Two-flop synchroniser; resets to the idle (mark) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist;

  // History of the two previous tick samples; a lone glitching sample is
  // always outvoted by its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (!rx_en) begin
      hist <= 2'b11;
    end else if (rx_clk_en) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign rx_filt = majority3(hist[1], hist[0], rx_s);
`else
  assign rx_filt = rx_s;
`endif

  // Filtered level, its previous tick value and the sample counter all move
  // only on ticks, so the downstream controller sees tick-aligned inputs.
  // Forcing the line history to 1 while disabled prevents a false start edge
  // when the receiver is re-enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync      <= 1'b1;
      rx_sync_prev <= 1'b1;
      smp_cnt      <= '0;
    end else if (!rx_en) begin
      rx_sync      <= 1'b1;
      rx_sync_prev <= 1'b1;
      smp_cnt      <= '0;
    end else if (rx_clk_en) begin
      rx_sync      <= rx_filt;
      rx_sync_prev <= rx_sync;
      smp_cnt      <= rx_sample_cnt_reset ? '0 : smp_cnt + SMP_ONE;
    end
  end

  assign rx_sync_fall  = rx_clk_en & rx_sync_prev & ~rx_sync;

  // A counter restart on the same tick wins over the strobe.
  assign rx_get_sample = rx_clk_en & ~rx_sample_cnt_reset & (smp_cnt == SMP_MID);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frontend
// Self-checking bench for uart_rx_frontend (OVERSAMPLE=16). Expected timing
// and data come from bit-period arithmetic and a small frame-level model of
// the RX controller. Honours UART_RX_MAJORITY_VOTE_EN for the glitch case.
// ---------------------------------------------------------------------------
module tb_uart_rx_frontend;

  localparam int OS = 16;

  logic        clk;
  logic        reset;
  logic        rx_en;
  logic [15:0] baud_div;
  logic        rx;
  logic        rx_sample_cnt_reset;
  logic        rx_clk_en;
  logic        rx_sync;
  logic        rx_sync_fall;
  logic        rx_get_sample;

  // Controller model: while idle it echoes a detected start edge back as
  // the bit-timing restart.
  logic ctl_idle;

  int checks;
  int failures;

  assign rx_sample_cnt_reset = ctl_idle & rx_sync_fall;

  uart_rx_frontend #(
    .OVERSAMPLE (OS),
    .DIV_WIDTH  (16)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .rx_en               (rx_en),
    .baud_div            (baud_div),
    .rx                  (rx),
    .rx_sample_cnt_reset (rx_sample_cnt_reset),
    .rx_clk_en           (rx_clk_en),
    .rx_sync             (rx_sync),
    .rx_sync_fall        (rx_sync_fall),
    .rx_get_sample       (rx_get_sample)
  );

  always #5 clk = ~clk;

  // Advance one cycle and land 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int nticks;
    int nfall;
    int last_tick;
    int bad_gap;
    $display("[TB] test_reset");
    rx_en = 1'b1;
    baud_div = 16'd3;
    rx = 1'b1;
    ctl_idle = 1'b0;
    repeat (20) step();
    rx = 1'b0;
    repeat (30) step();
    checks++;
    if (rx_sync !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pre_reset_sync_low: got %b expected 0", rx_sync);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({rx_sync, rx_clk_en, rx_sync_fall, rx_get_sample} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got sync/tick/fall/samp=%b expected 1000",
               {rx_sync, rx_clk_en, rx_sync_fall, rx_get_sample});
    end
    rx = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    nticks = 0;
    nfall = 0;
    last_tick = 0;
    bad_gap = 0;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (rx_sync_fall) nfall++;
      if (rx_clk_en) begin
        nticks++;
        if (i - last_tick != 4) bad_gap++;
        last_tick = i;
      end
    end
    checks++;
    if (nticks != 20) begin
      failures++;
      $display("[TB] FAIL idle_tick_count: got %0d expected 20", nticks);
    end
    checks++;
    if (bad_gap != 0) begin
      failures++;
      $display("[TB] FAIL idle_tick_spacing: got %0d bad gaps expected 0", bad_gap);
    end
    checks++;
    if (nfall != 0) begin
      failures++;
      $display("[TB] FAIL idle_no_fall: got %0d falls expected 0", nfall);
    end
  endtask

  task automatic test_start_bit();
    int bd;
    int nfall;
    int fall_at;
    int samp_at[$];
    logic first_level;
    bd = $urandom_range(1, 6);
    $display("[TB] test_start_bit baud_div=%0d", bd);
    baud_div = 16'(bd);
    rx = 1'b1;
    ctl_idle = 1'b1;
    repeat (10 * (bd + 1)) step();
    rx = 1'b0;
    nfall = 0;
    fall_at = -1;
    first_level = 1'bx;
    for (int i = 1; i <= 60 * (bd + 1); i++) begin
      step();
      if (rx_get_sample && fall_at >= 0) begin
        if (samp_at.size() == 0) first_level = rx_sync;
        samp_at.push_back(i);
      end
      if (rx_sync_fall) begin
        nfall++;
        if (fall_at < 0) fall_at = i;
      end
    end
    ctl_idle = 1'b0;
    checks++;
    if (nfall != 1) begin
      failures++;
      $display("[TB] FAIL start_fall_count: got %0d expected 1", nfall);
    end
    checks++;
    if (samp_at.size() < 3) begin
      failures++;
      $display("[TB] FAIL start_sample_count: got %0d expected at least 3", samp_at.size());
    end else begin
      checks++;
      if (samp_at[0] - fall_at != (OS / 2) * (bd + 1)) begin
        failures++;
        $display("[TB] FAIL first_sample_delay: got %0d cycles expected %0d",
                 samp_at[0] - fall_at, (OS / 2) * (bd + 1));
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (samp_at[k] - samp_at[k-1] != OS * (bd + 1)) begin
          failures++;
          $display("[TB] FAIL sample_period_%0d: got %0d cycles expected %0d",
                   k, samp_at[k] - samp_at[k-1], OS * (bd + 1));
        end
      end
      checks++;
      if (first_level !== 1'b0) begin
        failures++;
        $display("[TB] FAIL start_bit_level: got %b expected 0", first_level);
      end
    end
    rx = 1'b1;
    repeat (20 * (bd + 1)) step();
  endtask

  task automatic test_full_frame();
    logic [7:0] data;
    logic       bits [10];
    logic       got_bits [10];
    int         bd;
    int         bitlen;
    int         got;
    logic       pending;
    for (int f = 0; f < 4; f++) begin
      data = (f == 0) ? 8'h5A : 8'($urandom_range(0, 255));
      bd = $urandom_range(1, 4);
      $display("[TB] test_full_frame data=%02h baud_div=%0d", data, bd);
      baud_div = 16'(bd);
      bitlen = OS * (bd + 1);
      bits[0] = 1'b0;
      for (int b = 0; b < 8; b++) bits[b+1] = data[b];
      bits[9] = 1'b1;
      for (int b = 0; b < 10; b++) got_bits[b] = 1'bx;
      rx = 1'b1;
      ctl_idle = 1'b1;
      repeat (20 * (bd + 1)) step();
      got = 0;
      pending = 1'b0;
      for (int c = 0; c < 12 * bitlen; c++) begin
        step();
        if (pending) begin
          ctl_idle = 1'b0;
          pending = 1'b0;
        end
        if (!ctl_idle && rx_get_sample && got < 10) begin
          got_bits[got] = rx_sync;
          got++;
          if (got == 10) ctl_idle = 1'b1;
        end
        if (ctl_idle && rx_sync_fall && got == 0) pending = 1'b1;
        rx = (c < 10 * bitlen) ? bits[c / bitlen] : 1'b1;
      end
      ctl_idle = 1'b0;
      checks++;
      if (got != 10) begin
        failures++;
        $display("[TB] FAIL frame_strobe_count: got %0d expected 10", got);
      end
      for (int b = 0; b < 10; b++) begin
        checks++;
        if (got_bits[b] !== bits[b]) begin
          failures++;
          $display("[TB] FAIL frame_bit_%0d: got %b expected %b (data %02h)",
                   b, got_bits[b], bits[b], data);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int nfall;
    int exp_fall;
`ifdef UART_RX_MAJORITY_VOTE_EN
    exp_fall = 0;
`else
    exp_fall = 1;
`endif
    $display("[TB] test_glitch");
    baud_div = 16'd3;
    rx = 1'b1;
    ctl_idle = 1'b0;
    repeat (40 + $urandom_range(0, 3)) step();
    rx = 1'b0;
    nfall = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (i == 3) rx = 1'b1;
      if (rx_sync_fall) nfall++;
    end
    checks++;
    if (nfall != exp_fall) begin
      failures++;
      $display("[TB] FAIL glitch_fall_count: got %0d expected %0d", nfall, exp_fall);
    end
    checks++;
    if (rx_sync !== 1'b1) begin
      failures++;
      $display("[TB] FAIL glitch_sync_recovered: got %b expected 1", rx_sync);
    end
  endtask

  task automatic test_divisor_change();
    int early;
    int run;
    int new_div;
    logic exp_tick;
    run = $urandom_range(20, 90);
    new_div = $urandom_range(1, 9);
    $display("[TB] test_divisor_change cnt=%0d new_div=%0d", run, new_div);
    rx_en = 1'b0;
    baud_div = 16'd100;
    repeat (3) step();
    rx_en = 1'b1;
    early = 0;
    repeat (run) begin
      step();
      if (rx_clk_en) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("[TB] FAIL div_no_early_tick: got %0d ticks expected 0", early);
    end
    baud_div = 16'(new_div);
    step();
    checks++;
    if (rx_clk_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL div_change_immediate_tick: got %b expected 1", rx_clk_en);
    end
    for (int i = 1; i <= 3 * (new_div + 1); i++) begin
      step();
      exp_tick = (i % (new_div + 1) == 0);
      checks++;
      if (rx_clk_en !== exp_tick) begin
        failures++;
        $display("[TB] FAIL div_new_period_cycle_%0d: got %b expected %b", i, rx_clk_en, exp_tick);
      end
    end
  endtask

  task automatic test_enable_gating();
    int bd;
    int first_tick;
    int first_samp;
    int nfall;
    int bad;
    bd = $urandom_range(1, 4);
    $display("[TB] test_enable_gating baud_div=%0d", bd);
    baud_div = 16'(bd);
    rx_en = 1'b1;
    rx = 1'b1;
    ctl_idle = 1'b0;
    repeat (10 * (bd + 1) + $urandom_range(0, 7)) step();
    rx_en = 1'b0;
    rx = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({rx_clk_en, rx_sync_fall, rx_get_sample, rx_sync} !== 4'b0001) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL disabled_outputs_quiet: got %0d bad cycles expected 0", bad);
    end
    rx_en = 1'b1;
    rx = 1'b1;
    first_tick = -1;
    first_samp = -1;
    nfall = 0;
    for (int i = 1; i <= (OS / 2) * (bd + 1) + 4; i++) begin
      step();
      if (rx_clk_en && first_tick < 0) first_tick = i;
      if (rx_get_sample && first_samp < 0) first_samp = i;
      if (rx_sync_fall) nfall++;
    end
    checks++;
    if (first_tick != bd + 1) begin
      failures++;
      $display("[TB] FAIL reenable_first_tick: got cycle %0d expected %0d", first_tick, bd + 1);
    end
    checks++;
    if (first_samp != (OS / 2) * (bd + 1)) begin
      failures++;
      $display("[TB] FAIL reenable_first_sample: got cycle %0d expected %0d",
               first_samp, (OS / 2) * (bd + 1));
    end
    checks++;
    if (nfall != 0) begin
      failures++;
      $display("[TB] FAIL reenable_no_fall: got %0d falls expected 0", nfall);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    rx_en = 1'b1;
    baud_div = 16'd3;
    rx = 1'b1;
    ctl_idle = 1'b0;
    checks = 0;
    failures = 0;
    repeat (3) step();
    reset = 1'b0;
    test_reset();
    test_start_bit();
    test_full_frame();
    test_glitch();
    test_divisor_change();
    test_enable_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Receive-side front end of the UART, directly upstream of the RX controller FSM. It synchronises the asynchronous `rx` pin, generates the oversampling tick (`rx_clk_en`) from a programmable divisor, and filters the line into `rx_sync`. It also detects start-bit falling edges (`rx_sync_fall`) and produces the mid-bit sample strobe (`rx_get_sample`) that the controller and RX datapath consume.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters
- `OVERSAMPLE`, default 16: ticks per bit. Must be a power of two, ≥ 4.
- `DIV_WIDTH`, default 16: width of the baud divisor.

Ports
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `rx_en`  in  1: receiver enable.
- `baud_div`  in  DIV_WIDTH: tick period is `baud_div+1` clk cycles.
- `rx`  in  1: raw serial input pin, asynchronous.
- `rx_sample_cnt_reset`  in  1: from the controller; restarts bit timing.
- `rx_clk_en`  out  1: oversampling tick, single-cycle pulse.
- `rx_sync`  out  1: filtered line level, registered.
- `rx_sync_fall`  out  1: falling-edge pulse on `rx_sync`, tick-qualified.
- `rx_get_sample`  out  1: mid-bit strobe, tick-qualified.

## Operation
- **Synchroniser**
  - Two flops on `clk`, both reset to 1.
  - Output is `rx_s`.
- **Divider**
  - Counter `div_cnt` (DIV_WIDTH bits).
  - When `div_cnt >= baud_div`: `rx_clk_en`=1 for that cycle and `div_cnt`←0. Otherwise `div_cnt`++.
  - The `>=` compare guarantees a tick within one period after `baud_div` is lowered mid-operation.
  - `baud_div`=0 gives a tick every cycle.
- **Filter** (updates on ticks only)
  - Without vote: `rx_sync`←`rx_s`.
  - With vote: see Configuration.
- **Edge detect**
  - `rx_sync_prev`←`rx_sync` on each tick.
  - `rx_sync_fall` = `rx_clk_en & rx_sync_prev & ~rx_sync`.
- **Sample counter** `smp_cnt` (log2(OVERSAMPLE) bits), updates on ticks only:
  - If `rx_sample_cnt_reset`=1: `smp_cnt`←0.
  - Otherwise `smp_cnt`++, wrapping modulo OVERSAMPLE.
- **Sample strobe**
  - `rx_get_sample` = `rx_clk_en & ~rx_sample_cnt_reset & (smp_cnt == OVERSAMPLE/2-1)`.
  - Reset has priority over the strobe; the strobe is suppressed in that cycle.
  - `rx_sample_cnt_reset` is ignored when no tick is present.
- **`rx_en`=0**
  - `div_cnt` and `smp_cnt` are held at 0.
  - `rx_sync`, `rx_sync_prev` and the vote history are forced to 1.
  - All pulse outputs are 0.
  - On re-enable, no spurious fall pulse occurs.
- **Reset values**
  - All counters 0.
  - `rx_sync`, `rx_sync_prev`, history and synchroniser flops: 1.
  - `rx_clk_en`, `rx_sync_fall`, `rx_get_sample`: 0.

## Timing
- Pin to `rx_s`: 2 clk cycles.
- `rx_s` to `rx_sync`:
  - Next tick without vote.
  - Up to 2 ticks with vote.
- `rx_sync_fall` asserts on the tick after the tick on which `rx_sync` went 1→0.
- After a tick carrying `rx_sample_cnt_reset`, the first `rx_get_sample` is on the OVERSAMPLE/2-th subsequent tick. Thereafter it repeats every OVERSAMPLE ticks.
- All outputs change only in cycles where `rx_clk_en` is active, except `rx_clk_en` itself. The controller, which advances state only on `rx_clk_en`, therefore sees stable, tick-aligned inputs.
- Tick spacing is exactly `baud_div+1` cycles while `baud_div` is constant.

## Configuration
- Macro: `UART_RX_MAJORITY_VOTE_EN`.
- **Defined:**
  - 2-bit history `hist` shifts in `rx_s` on each tick.
  - On each tick, `rx_sync`←majority(`hist[1]`, `hist[0]`, `rx_s`).
  - A single-tick glitch never reaches `rx_sync`.
- **Undefined:** no history register; `rx_sync`←`rx_s` on each tick.

## Structure
- Package `uart_pkg`:
  - `UART_OVERSAMPLE_DEFAULT` = 16.
  - `UART_DIV_WIDTH_DEFAULT` = 16.
  - Shared with the TX side.
- Sub-module `uart_baud_gen`:
  - Contains the divider counter, `rx_en` hold and `rx_clk_en` generation.
  - Reused by the TX path.
- Synchroniser, filter, edge detect and sample counter are inline in `uart_rx_frontend`.

## Test plan
- **Reset and idle.** `reset` pulsed mid-frame with `baud_div`=3 → immediately: `rx_sync`=1 and all pulse outputs 0. After release: `rx_clk_en` every 4 cycles; no `rx_sync_fall` with `rx` held at 1.
- **Start-bit timing.** `baud_div`=3; drive `rx` 1→0; echo `rx_sample_cnt_reset` = `rx_sync_fall` → exactly one `rx_sync_fall`. The first `rx_get_sample` comes 8 ticks (32 cycles) later, then every 16 ticks (64 cycles).
- **Full frame.** 0x5A at 8N1, checked against a controller model → 10 `rx_get_sample` strobes, each with `rx_sync` equal to the transmitted bit.
- **Glitch (vote enabled).** 1-tick low pulse on `rx` → `rx_sync` stays 1; no `rx_sync_fall`. With the macro undefined → one `rx_sync_fall`.
- **Divisor change.** `baud_div` lowered 100→5 while `div_cnt`=50 → tick on the next cycle, then every 6 cycles.
- **Enable gating.** `rx_en`=0 for 20 cycles with `rx`=0, then `rx_en`=1 and `rx`=1 → no pulses throughout; counters restart from 0.
